// File: rtl/sseg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display: samples the an/sseg pins,
// recovers the four displayed hex digits and publishes them as one coherent frame.
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] sseg,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] blank,
  output logic       frame_valid,
  output logic       err,
  output logic       scan_lost
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, QUAL, ACCEPT, HOLD} state_t;

  state_t           state, next_state;
  logic [3:0]       an_meta, s_an, lat_an, next_lat_an;
  logic [6:0]       seg_meta, s_seg, lat_seg, next_lat_seg;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [3:0]       shadow_val [4];
  logic [3:0]       shadow_blank;
  logic [3:0]       mask;
  logic [TO_W-1:0]  to_cnt;
  logic             same_pair, one_low, dec_ok, dec_blank, acc_valid, acc_bad;
  logic [1:0]       idx;
  logic [3:0]       dec_val;
  logic [6:0]       pattern;

  // Two-stage synchronizer; idle pins (all off) are the safe reset value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      an_meta  <= 4'hF;
      s_an     <= 4'hF;
      seg_meta <= 7'h7F;
      s_seg    <= 7'h7F;
    end else begin
      an_meta  <= an;
      s_an     <= an_meta;
      seg_meta <= sseg;
      s_seg    <= seg_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      lat_an  <= 4'hF;
      lat_seg <= 7'h7F;
      cnt     <= '0;
    end else begin
      state   <= next_state;
      lat_an  <= next_lat_an;
      lat_seg <= next_lat_seg;
      cnt     <= next_cnt;
    end
  end

  assign same_pair = (s_an == lat_an) && (s_seg == lat_seg);

  always_comb begin
    next_state   = state;
    next_lat_an  = lat_an;
    next_lat_seg = lat_seg;
    next_cnt     = cnt;
    case (state)
      IDLE: begin
        if (s_an != 4'hF) begin
          next_state   = QUAL;
          next_lat_an  = s_an;
          next_lat_seg = s_seg;
          next_cnt     = CNT_W'(1);
        end
      end
      QUAL: begin
        // The first sample of a pair counts as one, so acceptance needs
        // STABLE_CYCLES identical samples in a row.
        if (!same_pair) begin
          if (s_an == 4'hF) begin
            next_state = IDLE;
          end else begin
            next_lat_an  = s_an;
            next_lat_seg = s_seg;
            next_cnt     = CNT_W'(1);
          end
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          next_state = ACCEPT;
          next_cnt   = cnt + CNT_W'(1);
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      ACCEPT: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (!same_pair) begin
          if (s_an == 4'hF) begin
            next_state = IDLE;
          end else begin
            next_state   = QUAL;
            next_lat_an  = s_an;
            next_lat_seg = s_seg;
            next_cnt     = CNT_W'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign pattern = ~lat_seg;

  always_comb begin
    idx       = 2'd0;
    one_low   = 1'b0;
    dec_ok    = 1'b1;
    dec_val   = 4'h0;
    dec_blank = 1'b0;
    case (lat_an)
      4'b1110: begin idx = 2'd0; one_low = 1'b1; end
      4'b1101: begin idx = 2'd1; one_low = 1'b1; end
      4'b1011: begin idx = 2'd2; one_low = 1'b1; end
      4'b0111: begin idx = 2'd3; one_low = 1'b1; end
      default: one_low = 1'b0;
    endcase
    case (pattern)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07, 7'h27: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

  assign acc_valid = (state == ACCEPT) && one_low && dec_ok;
  assign acc_bad   = (state == ACCEPT) && !(one_low && dec_ok);

  // Shadow capture, frame publication and scan-loss watchdog. A valid accept
  // always beats the watchdog terminal count in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) shadow_val[i] <= 4'h0;
      shadow_blank <= 4'hF;
      mask         <= 4'h0;
      d0           <= 4'h0;
      d1           <= 4'h0;
      d2           <= 4'h0;
      d3           <= 4'h0;
      blank        <= 4'hF;
      frame_valid  <= 1'b0;
      err          <= 1'b0;
      scan_lost    <= 1'b0;
      to_cnt       <= '0;
    end else begin
      frame_valid <= 1'b0;
      err         <= acc_bad;
      if (mask == 4'hF) begin
        d0          <= shadow_val[0];
        d1          <= shadow_val[1];
        d2          <= shadow_val[2];
        d3          <= shadow_val[3];
        blank       <= shadow_blank;
        frame_valid <= 1'b1;
        mask        <= 4'h0;
      end
      if (acc_valid) begin
        shadow_val[idx]   <= dec_val;
        shadow_blank[idx] <= dec_blank;
        mask[idx]         <= 1'b1;
        to_cnt            <= '0;
        scan_lost         <= 1'b0;
      end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          scan_lost <= 1'b1;
          mask      <= 4'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: directed scan scenarios plus a
// randomized dwell/ghost sequence checked against a dwell-level digit model.
module tb_sseg_scan_decoder;

  localparam int STABLE  = 16;
  localparam int TIMEOUT = 256;
  // Drive at a negedge: first capture edge, two sync stages, then STABLE samples.
  localparam int ACC_LAT = 1 + 2 + STABLE;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [3:0] a;
    logic [6:0] s;
    int         len;
  } seg_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] an = 4'hF;
  logic [6:0] sseg = 7'h7F;
  logic [3:0] d0, d1, d2, d3, blank;
  logic       frame_valid, err, scan_lost;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          err_cnt = 0;
  logic [19:0] act_frames [$];
  int          act_fv_cyc [$];

  sseg_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TO_W          (21)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .an         (an),
    .sseg       (sseg),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .blank      (blank),
    .frame_valid(frame_valid),
    .err        (err),
    .scan_lost  (scan_lost)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every published frame and every err cycle.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      act_frames.push_back({d3, d2, d1, d0, blank});
      act_fv_cyc.push_back(cyc);
    end
    if (err === 1'b1) err_cnt++;
  end

  function automatic logic [3:0] an_of(input int i);
    return ~(4'b0001 << i);
  endfunction

  function automatic logic [6:0] pins_of(input int v);
    return ~HEX[v];
  endfunction

  function automatic void model_decode(input logic [6:0] pins, output logic ok,
                                       output logic [3:0] v, output logic b);
    logic [6:0] p;
    p  = ~pins;
    ok = 1'b0;
    v  = 4'h0;
    b  = 1'b0;
    if (p == 7'h00) begin
      ok = 1'b1;
      b  = 1'b1;
    end else if (p == 7'h27) begin
      ok = 1'b1;
      v  = 4'h7;
    end else begin
      for (int i = 0; i < 16; i++) if (HEX[i] == p) begin ok = 1'b1; v = 4'(i); end
    end
  endfunction

  task automatic apply_stimulus(input logic [3:0] a, input logic [6:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    an    = 4'hF;
    sseg  = 7'h7F;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    act_frames.delete();
    act_fv_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    if ({d3, d2, d1, d0} !== 16'h0000) begin
      n_fail++; $display("[TB] FAIL reset_digits: got %h expected 0000", {d3, d2, d1, d0});
    end
    n_checks++;
    if (blank !== 4'hF) begin
      n_fail++; $display("[TB] FAIL reset_blank: got %b expected 1111", blank);
    end
    n_checks++;
    if ({frame_valid, err, scan_lost} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {frame_valid, err, scan_lost});
    end
    n_checks++;
    reset = 1'b1;
    repeat (30) @(negedge clk);
    if (act_frames.size() != 0 || err_cnt != 0) begin
      n_fail++; $display("[TB] FAIL idle_quiet: got frames=%0d errs=%0d expected 0 0", act_frames.size(), err_cnt);
    end
    n_checks++;
  endtask

  task automatic test_scan_1234();
    int t4 [2];
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 3; i >= 0; i--) begin
        if (i == 0) t4[r] = cyc;
        apply_stimulus(an_of(i), pins_of(4 - i), 64);
      end
    end
    apply_stimulus(4'hF, 7'h7F, 30);
    if (act_frames.size() != 2) begin
      n_fail++; $display("[TB] FAIL scan_frame_count: got %0d expected 2", act_frames.size());
    end
    n_checks++;
    for (int r = 0; r < 2 && r < act_frames.size(); r++) begin
      if (act_frames[r] !== 20'h12340) begin
        n_fail++; $display("[TB] FAIL scan_frame%0d: got %h expected 12340", r, act_frames[r]);
      end
      n_checks++;
      if (act_fv_cyc[r] - t4[r] != ACC_LAT + 1) begin
        n_fail++; $display("[TB] FAIL scan_latency%0d: got %0d expected %0d", r, act_fv_cyc[r] - t4[r], ACC_LAT + 1);
      end
      n_checks++;
    end
    if (err_cnt != 0) begin
      n_fail++; $display("[TB] FAIL scan_err: got %0d expected 0", err_cnt);
    end
    n_checks++;
  endtask

  task automatic test_glitch();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 3; i >= 0; i--) begin
        apply_stimulus(an_of(i), pins_of(4 - i), 64);
        // Ghost: next anode already enabled while the old segments linger.
        apply_stimulus(an_of((i == 0) ? 3 : i - 1), pins_of(4 - i), 8);
      end
    end
    apply_stimulus(4'hF, 7'h7F, 30);
    if (act_frames.size() != 2) begin
      n_fail++; $display("[TB] FAIL glitch_frame_count: got %0d expected 2", act_frames.size());
    end
    n_checks++;
    for (int r = 0; r < 2 && r < act_frames.size(); r++) begin
      if (act_frames[r] !== 20'h12340) begin
        n_fail++; $display("[TB] FAIL glitch_frame%0d: got %h expected 12340", r, act_frames[r]);
      end
      n_checks++;
    end
    if (err_cnt != 0) begin
      n_fail++; $display("[TB] FAIL glitch_err: got %0d expected 0", err_cnt);
    end
    n_checks++;
  endtask

  task automatic test_invalid();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 3; i >= 0; i--) begin
        apply_stimulus(an_of(i), (i == 2) ? ~7'h01 : pins_of(4 - i), 64);
      end
    end
    if (err_cnt != 2) begin
      n_fail++; $display("[TB] FAIL invalid_err_count: got %0d expected 2", err_cnt);
    end
    n_checks++;
    if (act_frames.size() != 0) begin
      n_fail++; $display("[TB] FAIL invalid_no_frame: got %0d expected 0", act_frames.size());
    end
    n_checks++;
    // Digits 3,1,0 stay captured; a good digit 2 completes the frame.
    for (int i = 3; i >= 0; i--) apply_stimulus(an_of(i), pins_of(4 - i), 64);
    apply_stimulus(4'hF, 7'h7F, 30);
    if (act_frames.size() != 1) begin
      n_fail++; $display("[TB] FAIL invalid_recover_count: got %0d expected 1", act_frames.size());
    end else if (act_frames[0] !== 20'h12340) begin
      n_fail++; $display("[TB] FAIL invalid_recover_frame: got %h expected 12340", act_frames[0]);
    end
    n_checks++;
  endtask

  task automatic test_blank_seven();
    do_reset();
    apply_stimulus(an_of(3), 7'h7F, 64);
    apply_stimulus(an_of(2), pins_of(5), 64);
    apply_stimulus(an_of(1), pins_of(10), 64);
    apply_stimulus(an_of(0), ~7'h27, 64);
    apply_stimulus(4'hF, 7'h7F, 30);
    if (act_frames.size() != 1) begin
      n_fail++; $display("[TB] FAIL blank7_count: got %0d expected 1", act_frames.size());
    end else if (act_frames[0] !== 20'h05A78) begin
      n_fail++; $display("[TB] FAIL blank7_frame: got %h expected 05a78", act_frames[0]);
    end
    n_checks++;
    if (err_cnt != 0) begin
      n_fail++; $display("[TB] FAIL blank7_err: got %0d expected 0", err_cnt);
    end
    n_checks++;
  endtask

  task automatic test_scan_stop();
    int t2, tr;
    do_reset();
    for (int i = 3; i >= 0; i--) apply_stimulus(an_of(i), pins_of(4 - i), 64);
    apply_stimulus(an_of(3), pins_of(9), 64);
    t2 = cyc;
    apply_stimulus(an_of(2), pins_of(8), 64);
    apply_stimulus(4'hF, 7'h7F, 1);
    while (cyc < t2 + ACC_LAT + TIMEOUT - 1) @(negedge clk);
    if (scan_lost !== 1'b0) begin
      n_fail++; $display("[TB] FAIL lost_early: got %b expected 0", scan_lost);
    end
    n_checks++;
    @(negedge clk);
    if (scan_lost !== 1'b1) begin
      n_fail++; $display("[TB] FAIL lost_at_timeout: got %b expected 1", scan_lost);
    end
    n_checks++;
    repeat (20) @(negedge clk);
    if ({d3, d2, d1, d0, blank} !== 20'h12340) begin
      n_fail++; $display("[TB] FAIL lost_retained: got %h expected 12340", {d3, d2, d1, d0, blank});
    end
    n_checks++;
    tr = cyc;
    apply_stimulus(an_of(1), pins_of(6), ACC_LAT - 1);
    if (scan_lost !== 1'b1 || cyc != tr + ACC_LAT - 1) begin
      n_fail++; $display("[TB] FAIL lost_before_accept: got %b expected 1", scan_lost);
    end
    n_checks++;
    @(negedge clk);
    if (scan_lost !== 1'b0) begin
      n_fail++; $display("[TB] FAIL lost_cleared: got %b expected 0", scan_lost);
    end
    n_checks++;
    repeat (64 - ACC_LAT) @(negedge clk);
    apply_stimulus(an_of(0), pins_of(7), 64);
    apply_stimulus(4'hF, 7'h7F, 30);
    if (act_frames.size() != 1) begin
      n_fail++; $display("[TB] FAIL lost_mask_cleared: got %0d frames expected 1", act_frames.size());
    end
    n_checks++;
    apply_stimulus(an_of(3), pins_of(9), 64);
    apply_stimulus(an_of(2), pins_of(8), 64);
    apply_stimulus(4'hF, 7'h7F, 30);
    if (act_frames.size() != 2) begin
      n_fail++; $display("[TB] FAIL lost_resume_count: got %0d expected 2", act_frames.size());
    end else if (act_frames[1] !== 20'h98670) begin
      n_fail++; $display("[TB] FAIL lost_resume_frame: got %h expected 98670", act_frames[1]);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 3; i >= 0; i--) apply_stimulus(an_of(i), pins_of(4 - i), 64);
    for (int i = 3; i >= 1; i--) apply_stimulus(an_of(i), pins_of(8 - i), 64);
    reset = 1'b0;
    an    = 4'hF;
    sseg  = 7'h7F;
    @(negedge clk);
    if ({d3, d2, d1, d0, blank} !== 20'h0000F) begin
      n_fail++; $display("[TB] FAIL midreset_outputs: got %h expected 0000f", {d3, d2, d1, d0, blank});
    end
    n_checks++;
    if ({frame_valid, err, scan_lost} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL midreset_flags: got %b expected 000", {frame_valid, err, scan_lost});
    end
    n_checks++;
    reset = 1'b1;
    act_frames.delete();
    act_fv_cyc.delete();
    apply_stimulus(an_of(0), pins_of(8), 64);
    apply_stimulus(4'hF, 7'h7F, 30);
    if (act_frames.size() != 0) begin
      n_fail++; $display("[TB] FAIL midreset_partial: got %0d frames expected 0", act_frames.size());
    end
    n_checks++;
    for (int i = 3; i >= 1; i--) apply_stimulus(an_of(i), pins_of(8 - i), 64);
    apply_stimulus(4'hF, 7'h7F, 30);
    if (act_frames.size() != 1) begin
      n_fail++; $display("[TB] FAIL midreset_count: got %0d expected 1", act_frames.size());
    end else if (act_frames[0] !== 20'h56780) begin
      n_fail++; $display("[TB] FAIL midreset_frame: got %h expected 56780", act_frames[0]);
    end
    n_checks++;
  endtask

  task automatic test_random();
    seg_t        plan [$];
    seg_t        merged [$];
    seg_t        x, g, last;
    logic [19:0] exp_frames [$];
    logic [3:0]  sv [4];
    logic [3:0]  sb, mk, v;
    logic        prev_bad, ok, b;
    logic [6:0]  bad_pat [4];
    int          exp_err, idx, kind, val;
    bad_pat = '{7'h01, 7'h02, 7'h40, 7'h08};
    prev_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      if (kind < 8 || prev_bad) begin
        val = $urandom_range(0, 16);
        x.a = an_of($urandom_range(0, 3));
        if (val == 16) x.s = 7'h7F;
        else if (val == 7 && $urandom_range(0, 1) == 1) x.s = ~7'h27;
        else x.s = pins_of(val);
        prev_bad = 1'b0;
      end else if (kind == 8) begin
        if ($urandom_range(0, 1) == 1) begin
          x.a = 4'b0011;
          x.s = pins_of($urandom_range(0, 15));
        end else begin
          x.a = an_of($urandom_range(0, 3));
          x.s = ~bad_pat[$urandom_range(0, 3)];
        end
        prev_bad = 1'b1;
      end else begin
        x.a = 4'hF;
        x.s = 7'($urandom_range(0, 127));
        prev_bad = 1'b1;
      end
      x.len = $urandom_range(20, 80);
      if (plan.size() > 0 && plan[plan.size()-1].a == x.a && plan[plan.size()-1].s == x.s)
        x.a = {x.a[2:0], x.a[3]};
      if (!prev_bad && $urandom_range(0, 1) == 1) begin
        g.a   = 4'($urandom_range(0, 15));
        g.s   = 7'($urandom_range(0, 127));
        g.len = $urandom_range(1, 10);
        plan.push_back(g);
      end
      plan.push_back(x);
    end
    x.a = 4'hF; x.s = 7'h7F; x.len = 40;
    plan.push_back(x);

    // Reference: a pin pair held for STABLE cycles is one digit event.
    foreach (plan[k]) begin
      if (merged.size() > 0 && merged[merged.size()-1].a == plan[k].a &&
          merged[merged.size()-1].s == plan[k].s) begin
        last = merged.pop_back();
        last.len += plan[k].len;
        merged.push_back(last);
      end else begin
        merged.push_back(plan[k]);
      end
    end
    for (int i = 0; i < 4; i++) sv[i] = 4'h0;
    sb = 4'h0; mk = 4'h0; exp_err = 0;
    foreach (merged[k]) begin
      if (merged[k].len < STABLE || merged[k].a == 4'hF) continue;
      idx = -1;
      for (int i = 0; i < 4; i++) if (merged[k].a == an_of(i)) idx = i;
      model_decode(merged[k].s, ok, v, b);
      if (idx >= 0 && ok) begin
        sv[idx] = v; sb[idx] = b; mk[idx] = 1'b1;
        if (mk == 4'hF) begin
          exp_frames.push_back({sv[3], sv[2], sv[1], sv[0], sb});
          mk = 4'h0;
        end
      end else begin
        exp_err++;
      end
    end

    do_reset();
    foreach (plan[k]) apply_stimulus(plan[k].a, plan[k].s, plan[k].len);
    if (act_frames.size() != exp_frames.size()) begin
      n_fail++; $display("[TB] FAIL random_frame_count: got %0d expected %0d", act_frames.size(), exp_frames.size());
    end
    n_checks++;
    for (int r = 0; r < exp_frames.size() && r < act_frames.size(); r++) begin
      if (act_frames[r] !== exp_frames[r]) begin
        n_fail++; $display("[TB] FAIL random_frame%0d: got %h expected %h", r, act_frames[r], exp_frames[r]);
      end
      n_checks++;
    end
    if (err_cnt != exp_err) begin
      n_fail++; $display("[TB] FAIL random_err_count: got %0d expected %0d", err_cnt, exp_err);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_glitch();
    test_invalid();
    test_blank_seven();
    test_scan_stop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
